// File: rtl/ddr2_req_pkg.sv
// Shared definitions for the DDR2 request queue: FSM encoding and FIFO entry layout.
// Entry layout is {we, addr, wdata}, with wdata in the LSBs.
package ddr2_req_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    function automatic int entry_w(input int aw, input int dw);
        return 1 + aw + dw;
    endfunction

    function automatic int addr_lsb(input int dw);
        return dw;
    endfunction

    function automatic int we_bit(input int aw, input int dw);
        return aw + dw;
    endfunction

endpackage

// File: rtl/ddr2_req_fifo.sv
// Synchronous FIFO with occupancy count; head is read combinationally from storage.
// A push while full is accepted only when a pop happens in the same cycle.
module ddr2_req_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ddr2_req_queue.sv
// Host request queue in front of the DDR2 controller: FIFO plus a one-at-a-time issue FSM.
// Optional abort of unacknowledged requests is enabled with the DDR2_REQ_TIMEOUT_EN macro.
module ddr2_req_queue
    import ddr2_req_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int AW      = 26,
    parameter int DW      = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   h_valid,
    output logic                   h_ready,
    input  logic                   h_we,
    input  logic [AW-1:0]          h_addr,
    input  logic [DW-1:0]          h_wdata,
    output logic                   rsp_valid,
    output logic [DW-1:0]          rsp_rdata,
    output logic [$clog2(DEPTH):0] q_count,
    output logic                   err,
    output logic [AW-1:0]          c_addr,
    output logic [DW-1:0]          c_data_in,
    output logic                   c_rd_req,
    output logic                   c_wr_req,
    input  logic                   c_rdy,
    input  logic                   c_ack,
    input  logic [DW-1:0]          c_data_out
);

    localparam int EW = entry_w(AW, DW);
    localparam int AL = addr_lsb(DW);
    localparam int WB = we_bit(AW, DW);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("ddr2_req_queue: DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
    end

    logic [1:0]    state;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          pop;
    logic          timed_out;

    assign h_ready = !rst && !full;
    assign pop     = (state == S_IDLE) && !empty && c_rdy;

    ddr2_req_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (h_valid && h_ready),
        .pop   (pop),
        .din   ({h_we, h_addr, h_wdata}),
        .dout  (head),
        .count (q_count),
        .full  (full),
        .empty (empty)
    );

`ifdef DDR2_REQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] timer;
    logic          err_q;

    assign timed_out = (timer == TW'(TIMEOUT - 1));
    assign err       = err_q;

    // Timer counts completed S_REQ cycles; it is restarted by the pop that enters S_REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            timer <= '0;
            err_q <= 1'b0;
        end else if (pop) begin
            timer <= '0;
        end else if (state == S_REQ) begin
            timer <= timer + 1'b1;
            if (!c_ack && timed_out) err_q <= 1'b1;
        end
    end
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            c_rd_req  <= 1'b0;
            c_wr_req  <= 1'b0;
            c_addr    <= '0;
            c_data_in <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        c_addr    <= head[AL +: AW];
                        c_data_in <= head[DW-1:0];
                        c_wr_req  <= head[WB];
                        c_rd_req  <= !head[WB];
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (c_ack) begin
                        c_rd_req <= 1'b0;
                        c_wr_req <= 1'b0;
                        if (c_rd_req) begin
                            rsp_rdata <= c_data_out;
                            rsp_valid <= 1'b1;
                        end
                        state <= S_WAIT;
                    end else if (timed_out) begin
                        c_rd_req <= 1'b0;
                        c_wr_req <= 1'b0;
                        state    <= S_WAIT;
                    end
                end
                // c_rdy is already low when c_ack arrives, so seeing it high means the controller finished.
                S_WAIT: begin
                    if (c_rdy) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr2_req_queue.sv
// Self-checking bench for ddr2_req_queue with a queue-based reference model and controller model.
// Build with DDR2_REQ_TIMEOUT_EN defined to also exercise the request timeout (TIMEOUT=16).
module tb_ddr2_req_queue;

    localparam int DEPTH   = 8;
    localparam int AW      = 26;
    localparam int DW      = 64;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH) + 1;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    logic          clk;
    logic          rst;
    logic          h_valid;
    logic          h_ready;
    logic          h_we;
    logic [AW-1:0] h_addr;
    logic [DW-1:0] h_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [CW-1:0] q_count;
    logic          err;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_data_in;
    logic          c_rd_req;
    logic          c_wr_req;
    logic          c_rdy;
    logic          c_ack;
    logic [DW-1:0] c_data_out;

    req_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    ddr2_req_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_we       (h_we),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .q_count    (q_count),
        .err        (err),
        .c_addr     (c_addr),
        .c_data_in  (c_data_in),
        .c_rd_req   (c_rd_req),
        .c_wr_req   (c_wr_req),
        .c_rdy      (c_rdy),
        .c_ack      (c_ack),
        .c_data_out (c_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // One host push; acceptance is predicted from the model occupancy.
    task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_t e;
        logic exp_rdy;
        @(negedge clk);
        h_valid = 1'b1;
        h_we    = we;
        h_addr  = addr;
        h_wdata = wdata;
        exp_rdy = (exp_q.size() < DEPTH);
        n_checks++;
        if (h_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL push_h_ready: got %0b expected %0b", h_ready, exp_rdy);
        end
        @(posedge clk);
        if (exp_rdy) begin
            e.we = we; e.addr = addr; e.wdata = wdata;
            exp_q.push_back(e);
        end
        #1;
        h_valid = 1'b0;
        n_checks++;
        if (q_count !== CW'(exp_q.size())) begin
            n_fail++;
            $display("FAIL push_q_count: got %0d expected %0d", q_count, exp_q.size());
        end
    endtask

    task automatic push_random();
        push_req(1'($urandom()), AW'($urandom()), {$urandom(), $urandom()});
    endtask

    // Controller model for one transaction: waits for a request, checks it against the model head,
    // acks after ack_delay cycles, then stays busy for busy_after cycles. Caller has c_rdy=1.
    task automatic serve_one(input int ack_delay, input int busy_after);
        req_t          e;
        bit            seen;
        logic [DW-1:0] rdata;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (c_rd_req || c_wr_req) seen = 1;
        end
        n_checks++;
        if (!seen || exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL serve_req_seen: got seen=%0b expected seen=1 with %0d queued", seen, exp_q.size());
            return;
        end
        e = exp_q.pop_front();
        c_rdy = 1'b0;
        for (int i = 0; i <= ack_delay; i++) begin
            if (i > 0) @(negedge clk);
            n_checks++;
            if ({c_wr_req, c_rd_req} !== {e.we, !e.we} || c_addr !== e.addr) begin
                n_fail++;
                $display("FAIL serve_req_hold: got wr=%0b rd=%0b addr=%0h expected wr=%0b rd=%0b addr=%0h",
                         c_wr_req, c_rd_req, c_addr, e.we, !e.we, e.addr);
            end
            if (e.we) begin
                n_checks++;
                if (c_data_in !== e.wdata) begin
                    n_fail++;
                    $display("FAIL serve_wdata: got %0h expected %0h", c_data_in, e.wdata);
                end
            end
            n_checks++;
            if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL serve_rsp_early: got %0b expected 0", rsp_valid);
            end
        end
        if (i_first_issue_count(e) == 0) begin end
        n_checks++;
        if (q_count !== CW'(exp_q.size())) begin
            n_fail++;
            $display("FAIL serve_q_count: got %0d expected %0d", q_count, exp_q.size());
        end
        rdata      = {$urandom(), $urandom()};
        c_ack      = 1'b1;
        c_data_out = rdata;
        @(negedge clk);
        c_ack = 1'b0;
        n_checks++;
        if ({c_wr_req, c_rd_req} !== 2'b00 || rsp_valid !== !e.we) begin
            n_fail++;
            $display("FAIL serve_after_ack: got wr=%0b rd=%0b rsp_valid=%0b expected 0 0 %0b",
                     c_wr_req, c_rd_req, rsp_valid, !e.we);
        end
        if (!e.we) begin
            n_checks++;
            if (rsp_rdata !== rdata) begin
                n_fail++;
                $display("FAIL serve_rsp_rdata: got %0h expected %0h", rsp_rdata, rdata);
            end
        end
        for (int i = 0; i < (busy_after < 1 ? 1 : busy_after); i++) begin
            @(negedge clk);
            n_checks++;
            if ({c_wr_req, c_rd_req, rsp_valid} !== 3'b000) begin
                n_fail++;
                $display("FAIL serve_busy_idle: got wr=%0b rd=%0b rsp_valid=%0b expected 0 0 0",
                         c_wr_req, c_rd_req, rsp_valid);
            end
        end
        c_rdy = 1'b1;
    endtask

    function automatic int i_first_issue_count(input req_t e);
        return e.we ? 1 : 1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; h_valid = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = '0;
        c_rdy = 1'b0; c_ack = 1'b0; c_data_out = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (h_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_h_ready_in_rst: got %0b expected 0", h_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({h_ready, c_rd_req, c_wr_req, rsp_valid, err} !== 5'b10000 || q_count !== '0 ||
            c_addr !== '0 || c_data_in !== '0 || rsp_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%0b rd=%0b wr=%0b rv=%0b err=%0b cnt=%0d addr=%0h din=%0h rdata=%0h expected 1 0 0 0 0 0 0 0 0",
                     h_ready, c_rd_req, c_wr_req, rsp_valid, err, q_count, c_addr, c_data_in, rsp_rdata);
        end
        exp_q.delete();
    endtask

    task automatic test_single_read();
        c_rdy = 1'b1;
        @(negedge clk);
        h_valid = 1'b1; h_we = 1'b0; h_addr = 26'h0001C05; h_wdata = '0;
        @(posedge clk);
        #1;
        h_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (c_rd_req !== 1'b0 || q_count !== CW'(1)) begin
            n_fail++;
            $display("FAIL read_latency_early: got rd=%0b cnt=%0d expected 0 1", c_rd_req, q_count);
        end
        @(negedge clk);
        n_checks++;
        if (c_rd_req !== 1'b1 || c_wr_req !== 1'b0 || c_addr !== 26'h0001C05 || q_count !== '0) begin
            n_fail++;
            $display("FAIL read_issue: got rd=%0b wr=%0b addr=%0h cnt=%0d expected 1 0 1c05 0",
                     c_rd_req, c_wr_req, c_addr, q_count);
        end
        c_rdy = 1'b0;
        c_ack = 1'b1;
        c_data_out = 64'hDEADBEEF_CAFEF00D;
        @(negedge clk);
        c_ack = 1'b0;
        n_checks++;
        if (c_rd_req !== 1'b0 || rsp_valid !== 1'b1 || rsp_rdata !== 64'hDEADBEEF_CAFEF00D) begin
            n_fail++;
            $display("FAIL read_response: got rd=%0b rv=%0b rdata=%0h expected 0 1 deadbeefcafef00d",
                     c_rd_req, rsp_valid, rsp_rdata);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL read_rsp_pulse: got %0b expected 0", rsp_valid);
        end
        c_rdy = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        c_rdy = 1'b0;
        push_req(1'b1, 26'h2ABCDEF, 64'h0123456789ABCDEF);
        c_rdy = 1'b1;
        serve_one(3, 0);
    endtask

    task automatic test_full();
        c_rdy = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push_random();
        @(negedge clk);
        n_checks++;
        if (q_count !== CW'(DEPTH) || h_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_state: got cnt=%0d rdy=%0b expected %0d 0", q_count, h_ready, DEPTH);
        end
        c_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) serve_one($urandom_range(0, 2), $urandom_range(0, 1));
    endtask

    task automatic test_stall();
        c_rdy = 1'b0;
        push_random();
        push_random();
        c_rdy = 1'b1;
        serve_one(1, 4);
        serve_one(0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int k;
            k = $urandom_range(1, DEPTH);
            c_rdy = 1'b0;
            for (int i = 0; i < k; i++) push_random();
            c_rdy = 1'b1;
            for (int i = 0; i < k; i++) serve_one($urandom_range(0, 3), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        c_rdy = 1'b0;
        for (int i = 0; i < 3; i++) push_req(1'b0, AW'($urandom()), '0);
        c_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (c_rd_req) seen = 1;
        end
        n_checks++;
        if (!seen || q_count !== CW'(2)) begin
            n_fail++;
            $display("FAIL rstmid_issue: got seen=%0b cnt=%0d expected 1 2", seen, q_count);
        end
        c_rdy = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({c_rd_req, c_wr_req, rsp_valid, h_ready} !== 4'b0000 || q_count !== '0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got rd=%0b wr=%0b rv=%0b rdy=%0b cnt=%0d expected 0 0 0 0 0",
                     c_rd_req, c_wr_req, rsp_valid, h_ready, q_count);
        end
        rst = 1'b0;
        exp_q.delete();
        c_rdy = 1'b1;
        c_ack = 1'b1;
        c_data_out = {$urandom(), $urandom()};
        @(negedge clk);
        c_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({c_rd_req, c_wr_req, rsp_valid, h_ready} !== 4'b0001 || q_count !== '0) begin
                n_fail++;
                $display("FAIL rstmid_after: got rd=%0b wr=%0b rv=%0b rdy=%0b cnt=%0d expected 0 0 0 1 0",
                         c_rd_req, c_wr_req, rsp_valid, h_ready, q_count);
            end
        end
    endtask

`ifdef DDR2_REQ_TIMEOUT_EN
    task automatic test_timeout();
        bit seen;
        bit bad_rsp;
        int high;
        c_rdy = 1'b0;
        push_req(1'b0, AW'($urandom()), '0);
        push_random();
        c_rdy = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (c_rd_req) seen = 1;
        end
        void'(exp_q.pop_front());
        c_rdy = 1'b0;
        high = seen ? 1 : 0;
        bad_rsp = 0;
        for (int i = 0; i < 3 * TIMEOUT && seen; i++) begin
            @(negedge clk);
            if (rsp_valid) bad_rsp = 1;
            if (c_rd_req || c_wr_req) high++;
            else break;
        end
        n_checks++;
        if (high !== TIMEOUT || err !== 1'b1 || bad_rsp) begin
            n_fail++;
            $display("FAIL timeout_abort: got high=%0d err=%0b rsp=%0b expected %0d 1 0",
                     high, err, bad_rsp, TIMEOUT);
        end
        c_rdy = 1'b1;
        serve_one(0, 0);
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_err_sticky: got %0b expected 1", err);
        end
    endtask
`endif

    initial begin
        logic exp_err;
        test_reset();
        test_single_read();
        test_single_write();
        test_full();
        test_stall();
        test_random();
`ifdef DDR2_REQ_TIMEOUT_EN
        test_timeout();
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        @(negedge clk);
        n_checks++;
        if (err !== exp_err || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_err: got err=%0b left=%0d expected %0b 0", err, exp_q.size(), exp_err);
        end
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
